// File: rtl/reaction_timer_mp.sv
// reaction_timer_mp: multi-player reaction timer with random wait, cheat/slow detection, winner and best-time record
module reaction_timer_mp #(
   parameter int NUM_PLAYERS = 2,
   parameter int TIME_W      = 10,
   parameter int RAND_W      = 13,
   parameter int TICK_DIV    = 50000,
   parameter int MIN_WAIT    = 500,
   parameter int MAX_TIME    = 1000,
   parameter int END_TICKS   = 1000,
   localparam int WIN_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          Start,
   input  logic [NUM_PLAYERS-1:0]        Press,
   input  logic [RAND_W-1:0]             RandomValue,
   input  logic                          LCDAck,
   output logic [7:0]                    LED,
   output logic                          LCDUpdate,
   output logic                          Wait,
   output logic [NUM_PLAYERS-1:0]        Cheat,
   output logic [NUM_PLAYERS-1:0]        Slow,
   output logic [NUM_PLAYERS*TIME_W-1:0] ReactionTime,
   output logic [WIN_W-1:0]              Winner,
   output logic                          WinValid,
   output logic [TIME_W-1:0]             BestTime
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int EW = $clog2(END_TICKS + 1);

   typedef enum logic [2:0] {IDLE, WAIT_MSG, RANDOM_WAIT, MEASURE, DISPLAY, END_WAIT} state_t;

   state_t                  state;
   logic [PW-1:0]           presc;
   logic                    tick;
   logic [NUM_PLAYERS-1:0]  press_q, press_edge, active, hit, left;
   logic [RAND_W-1:0]       wait_time, wait_cnt, wait_sel;
   logic [TIME_W-1:0]       meas_cnt, win_time;
   logic [EW-1:0]           end_cnt;
   logic [WIN_W-1:0]        first;
   logic                    timeout;

   assign tick       = presc == PW'(TICK_DIV - 1);
   assign press_edge = Press & ~press_q;
   assign hit        = press_edge & active;
   assign left       = active & ~hit;
   assign timeout    = meas_cnt == TIME_W'(MAX_TIME);
   assign wait_sel   = (RandomValue > RAND_W'(MIN_WAIT)) ? RandomValue : RAND_W'(MIN_WAIT);
   assign win_time   = ReactionTime[int'(Winner)*TIME_W +: TIME_W];
   assign LED        = (state == MEASURE) ? 8'hFF : 8'h00;
   assign Wait       = (state == WAIT_MSG) || (state == RANDOM_WAIT);
   assign LCDUpdate  = (state == WAIT_MSG) || (state == DISPLAY);

   // lowest-index scoring player this cycle, so same-cycle ties favour player 0
   always_comb begin
      first = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--)
         if (hit[i]) first = WIN_W'(i);
   end

   // game sequencer: prescaler, per-state counters, per-player results and best-time record
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state        <= IDLE;
         presc        <= '0;
         press_q      <= '0;
         active       <= '0;
         wait_time    <= '0;
         wait_cnt     <= '0;
         meas_cnt     <= '0;
         end_cnt      <= '0;
         Cheat        <= '0;
         Slow         <= '0;
         ReactionTime <= '0;
         Winner       <= '0;
         WinValid     <= 1'b0;
         BestTime     <= '1;
      end else begin
         press_q <= Press;
         presc   <= tick ? '0 : presc + PW'(1);
         case (state)
            IDLE: if (Start) begin
               state        <= WAIT_MSG;
               presc        <= '0;
               active       <= '1;
               Cheat        <= '0;
               Slow         <= '0;
               ReactionTime <= '0;
               Winner       <= '0;
               WinValid     <= 1'b0;
            end
            WAIT_MSG: if (LCDAck) begin
               wait_time <= wait_sel;
               wait_cnt  <= '0;
               state     <= RANDOM_WAIT;
               presc     <= '0;
            end
            RANDOM_WAIT: begin
               if (tick && wait_cnt != wait_time) wait_cnt <= wait_cnt + RAND_W'(1);
               Cheat  <= Cheat | hit;
               active <= left;
               if (left == '0) begin
                  state <= DISPLAY;
                  presc <= '0;
               end else if (wait_cnt == wait_time) begin
                  state    <= MEASURE;
                  presc    <= '0;
                  meas_cnt <= '0;
               end
            end
            MEASURE: begin
               if (tick && !timeout) meas_cnt <= meas_cnt + TIME_W'(1);
               for (int i = 0; i < NUM_PLAYERS; i++)
                  if (hit[i] || (timeout && active[i])) ReactionTime[i*TIME_W +: TIME_W] <= meas_cnt;
               if (hit != '0 && !WinValid) begin
                  Winner   <= first;
                  WinValid <= 1'b1;
               end
               if (timeout) begin
                  Slow   <= Slow | left;
                  active <= '0;
                  state  <= DISPLAY;
                  presc  <= '0;
               end else begin
                  active <= left;
                  if (left == '0) begin
                     state <= DISPLAY;
                     presc <= '0;
                  end
               end
            end
            DISPLAY: if (LCDAck) begin
               if (WinValid && win_time < BestTime) BestTime <= win_time;
               end_cnt <= '0;
               state   <= END_WAIT;
               presc   <= '0;
            end
            END_WAIT: begin
               if (tick && !Start && end_cnt != EW'(END_TICKS)) end_cnt <= end_cnt + EW'(1);
               if (end_cnt == EW'(END_TICKS)) begin
                  state <= IDLE;
                  presc <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
